// File: rtl/local_bp_tagged.sv
// Two-level local-history branch predictor with a tagged BTB, two fetch ports and two update ports.
// A sweep after reset clears the tables; ready rises once the sweep has finished.
module local_bp_tagged #(
  parameter int BTB_IDX_BITS = 10,
  parameter int TAG_BITS     = 8,
  parameter int BHT_IDX_BITS = 12,
  parameter int HIST_BITS    = 2,
  parameter int PHT_PC_BITS  = 10,
  parameter int CTR_BITS     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] RA1,
  input  logic [31:0] RA2,
  input  logic        WE1,
  input  logic        WE2,
  input  logic [31:0] WA1,
  input  logic [31:0] WA2,
  input  logic [31:0] WD1,
  input  logic [31:0] WD2,
  input  logic        US1,
  input  logic        US2,
  input  logic        T1,
  input  logic        T2,
  output logic        P1,
  output logic        P2,
  output logic        HIT1,
  output logic        HIT2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        ready
);

  localparam int PHT_IDX_BITS = PHT_PC_BITS + HIST_BITS;
  localparam int BTB_N        = 1 << BTB_IDX_BITS;
  localparam int BHT_N        = 1 << BHT_IDX_BITS;
  localparam int PHT_N        = 1 << PHT_IDX_BITS;
  localparam int SW_A         = (BTB_IDX_BITS > BHT_IDX_BITS) ? BTB_IDX_BITS : BHT_IDX_BITS;
  localparam int SW           = (SW_A > PHT_IDX_BITS) ? SW_A : PHT_IDX_BITS;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] cnt_reg, cnt_next;
  logic          ready_reg;
  logic          run_active;

  logic [TAG_BITS-1:0]  btb_tag    [BTB_N];
  logic [31:0]          btb_target [BTB_N];
  logic                 btb_valid  [BTB_N];
  logic [HIST_BITS-1:0] bht        [BHT_N];
  logic [CTR_BITS-1:0]  pht        [PHT_N];

  function automatic logic [CTR_BITS-1:0] sat_step(input logic [CTR_BITS-1:0] c, input logic t);
    if (t)
      return (c == '1) ? c : c + CTR_BITS'(1);
    return (c == '0) ? c : c - CTR_BITS'(1);
  endfunction

  // ---------------- sweep / run control ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_INIT;
      cnt_reg   <= '0;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= (state_next == ST_RUN);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_INIT: begin
        cnt_next = cnt_reg + SW'(1);
        if (cnt_reg == '1)
          state_next = ST_RUN;
      end
      ST_RUN:  state_next = ST_RUN;
      default: state_next = ST_INIT;
    endcase
  end

  assign run_active = (state_reg == ST_RUN) && !reset;
  assign ready      = ready_reg;

  // ---------------- direction update path ----------------
  // Port 2 sees port 1's freshly written history/counter, so the pair behaves as two serial updates.
  logic [BHT_IDX_BITS-1:0] h1_idx, h2_idx;
  logic [HIST_BITS-1:0]    h1_old, h2_old, h1_new, h2_new;
  logic [HIST_BITS:0]      h1_sh, h2_sh;
  logic [PHT_IDX_BITS-1:0] p1_idx, p2_idx;
  logic [CTR_BITS-1:0]     c1_old, c2_old, c1_new, c2_new;

  assign h1_idx = WA1[BHT_IDX_BITS+1:2];
  assign h1_old = bht[h1_idx];
  assign p1_idx = {WA1[PHT_PC_BITS+1:2], h1_old};
  assign c1_old = pht[p1_idx];
  assign c1_new = sat_step(c1_old, T1);
  assign h1_sh  = {h1_old, T1};
  assign h1_new = h1_sh[HIST_BITS-1:0];

  assign h2_idx = WA2[BHT_IDX_BITS+1:2];
  assign h2_old = (US1 && (h2_idx == h1_idx)) ? h1_new : bht[h2_idx];
  assign p2_idx = {WA2[PHT_PC_BITS+1:2], h2_old};
  assign c2_old = (US1 && (p2_idx == p1_idx)) ? c1_new : pht[p2_idx];
  assign c2_new = sat_step(c2_old, T2);
  assign h2_sh  = {h2_old, T2};
  assign h2_new = h2_sh[HIST_BITS-1:0];

  logic unused_bits;
  assign unused_bits = ^{WA1, WA2, h1_sh[HIST_BITS], h2_sh[HIST_BITS]};

  // ---------------- table writes ----------------
  // Port 2 assignments come last so they win on any index collision.
  always_ff @(posedge clk) begin
    if (!reset && state_reg == ST_INIT) begin
      if (int'(cnt_reg) < BTB_N)
        btb_valid[cnt_reg[BTB_IDX_BITS-1:0]] <= 1'b0;
      if (int'(cnt_reg) < BHT_N)
        bht[cnt_reg[BHT_IDX_BITS-1:0]] <= '0;
      if (int'(cnt_reg) < PHT_N)
        pht[cnt_reg[PHT_IDX_BITS-1:0]] <= '0;
    end else if (run_active) begin
      if (WE1) begin
        btb_valid[WA1[BTB_IDX_BITS+1:2]]  <= 1'b1;
        btb_tag[WA1[BTB_IDX_BITS+1:2]]    <= WA1[BTB_IDX_BITS+2 +: TAG_BITS];
        btb_target[WA1[BTB_IDX_BITS+1:2]] <= WD1;
      end
      if (WE2) begin
        btb_valid[WA2[BTB_IDX_BITS+1:2]]  <= 1'b1;
        btb_tag[WA2[BTB_IDX_BITS+1:2]]    <= WA2[BTB_IDX_BITS+2 +: TAG_BITS];
        btb_target[WA2[BTB_IDX_BITS+1:2]] <= WD2;
      end
      if (US1) begin
        bht[h1_idx] <= h1_new;
        pht[p1_idx] <= c1_new;
      end
      if (US2) begin
        bht[h2_idx] <= h2_new;
        pht[p2_idx] <= c2_new;
      end
    end
  end

  // ---------------- fetch read ports ----------------
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [31:0]             pc;
      logic [BTB_IDX_BITS-1:0] bi;
      logic [BHT_IDX_BITS-1:0] hi;
      logic [PHT_IDX_BITS-1:0] pi;
      logic                    hit;
      logic                    p_reg, hit_reg;
      logic [31:0]             rd_reg;
      logic                    unused_pc;

      assign pc        = (gi == 0) ? RA1 : RA2;
      assign bi        = pc[BTB_IDX_BITS+1:2];
      assign hi        = pc[BHT_IDX_BITS+1:2];
      assign pi        = {pc[PHT_PC_BITS+1:2], bht[hi]};
      assign hit       = btb_valid[bi] && (btb_tag[bi] == pc[BTB_IDX_BITS+2 +: TAG_BITS]);
      assign unused_pc = ^pc;

      always_ff @(posedge clk) begin
        if (!run_active) begin
          p_reg   <= 1'b0;
          hit_reg <= 1'b0;
          rd_reg  <= '0;
        end else begin
          p_reg   <= pht[pi][CTR_BITS-1];
          hit_reg <= hit;
          rd_reg  <= hit ? btb_target[bi] : 32'h0;
        end
      end
    end
  endgenerate

  assign P1   = g_rd[0].p_reg;
  assign HIT1 = g_rd[0].hit_reg;
  assign RD1  = g_rd[0].rd_reg;
  assign P2   = g_rd[1].p_reg;
  assign HIT2 = g_rd[1].hit_reg;
  assign RD2  = g_rd[1].rd_reg;

endmodule
